// File: rtl/axi_wr_arbiter.sv
// Write-path controller: round-robin AW arbitration between M1/M2, slave decode,
// W-channel routing lock from AW through B, WLAST length check and a hang watchdog.
module axi_wr_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid_m1,
    input  logic [31:0] awaddr_m1,
    input  logic [3:0]  awlen_m1,
    input  logic        awvalid_m2,
    input  logic [31:0] awaddr_m2,
    input  logic [3:0]  awlen_m2,
    input  logic        aw_hs,
    input  logic        w_hs,
    input  logic        wlast,
    input  logic        b_hs,
    output logic [1:0]  grant,
    output logic [5:0]  slave_sel,
    output logic        decerr,
    output logic [1:0]  phase,
    output logic        wlast_err,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last_grant;   // 0 = M1 was served last, 1 = M2
    logic [3:0]       beat_cnt;
    logic [CNT_W-1:0] wd_cnt;

    logic             pick_m2;
    logic [31:0]      win_addr;
    logic [6:0]       win_dec;
    logic             any_hs;
    logic             wd_expire;

    // Returns {decerr, slave_sel}.
    function automatic logic [6:0] decode(input logic [15:0] hi);
        logic [6:0] r;
        case (hi)
            16'h0000: r = 7'b0_000001;
            16'h0001: r = 7'b0_000010;
            16'h0002: r = 7'b0_000100;
            16'h1002: r = 7'b0_001000;
            16'h1001: r = 7'b0_010000;
            default:  r = (hi >= 16'h2000 && hi <= 16'h201F) ? 7'b0_100000 : 7'b1_000000;
        endcase
        return r;
    endfunction

    // M2 wins when it is the only requester, or when both request and M1 went last.
    assign pick_m2   = awvalid_m2 && (!awvalid_m1 || !last_grant);
    assign win_addr  = pick_m2 ? awaddr_m2 : awaddr_m1;
    assign win_dec   = decode(win_addr[31:16]);
    assign any_hs    = aw_hs | w_hs | b_hs;
    assign wd_expire = (state != IDLE) && !any_hs && (wd_cnt == WD_LAST);
    assign phase     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            slave_sel  <= 6'b0;
            decerr     <= 1'b0;
            wlast_err  <= 1'b0;
            timeout    <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= 4'd0;
            wd_cnt     <= '0;
        end else begin
            wlast_err <= 1'b0;
            timeout   <= 1'b0;
            // Every state change coincides with IDLE or a handshake, so this also covers entry.
            if (state == IDLE || any_hs)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;

            if (wd_expire) begin
                state      <= IDLE;
                grant      <= 2'b00;
                slave_sel  <= 6'b0;
                decerr     <= 1'b0;
                timeout    <= 1'b1;
                last_grant <= grant[1];
            end else begin
                case (state)
                    IDLE: if (awvalid_m1 || awvalid_m2) begin
                        grant               <= pick_m2 ? 2'b10 : 2'b01;
                        {decerr, slave_sel} <= win_dec;
                        state               <= ADDR;
                    end
                    ADDR: if (aw_hs) begin
                        beat_cnt <= grant[1] ? awlen_m2 : awlen_m1;
                        state    <= DATA;
                    end
                    DATA: if (w_hs) begin
                        wlast_err <= (beat_cnt == 4'd0 && !wlast) || (beat_cnt != 4'd0 && wlast);
                        if (beat_cnt != 4'd0)
                            beat_cnt <= beat_cnt - 1'b1;
                        if (wlast)
                            state <= RESP;
                    end
                    RESP: if (b_hs) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        slave_sel  <= 6'b0;
                        decerr     <= 1'b0;
                        last_grant <= grant[1];
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized self-checking bench for axi_wr_arbiter against a transaction-level model.
module tb_axi_wr_arbiter;

    logic        clk, rst;
    logic        awvalid_m1, awvalid_m2;
    logic [31:0] awaddr_m1, awaddr_m2;
    logic [3:0]  awlen_m1, awlen_m2;
    logic        aw_hs, w_hs, wlast, b_hs;
    logic [1:0]  grant, phase;
    logic [5:0]  slave_sel;
    logic        decerr, wlast_err, timeout;

    axi_wr_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .awvalid_m1(awvalid_m1), .awaddr_m1(awaddr_m1), .awlen_m1(awlen_m1),
        .awvalid_m2(awvalid_m2), .awaddr_m2(awaddr_m2), .awlen_m2(awlen_m2),
        .aw_hs(aw_hs), .w_hs(w_hs), .wlast(wlast), .b_hs(b_hs),
        .grant(grant), .slave_sel(slave_sel), .decerr(decerr), .phase(phase),
        .wlast_err(wlast_err), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int err_pulses = 0, to_pulses = 0;
    bit model_last_m2;

    always @(negedge clk) begin
        if (wlast_err === 1'b1) err_pulses++;
        if (timeout === 1'b1) to_pulses++;
    end

    localparam logic [15:0] RLO [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h1002, 16'h1001, 16'h2000};
    localparam logic [15:0] RHI [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h1002, 16'h1001, 16'h201F};

    // Reference model: {decerr, slave_sel} from the address map table.
    function automatic logic [6:0] ref_decode(input logic [31:0] a);
        int idx;
        idx = -1;
        for (int n = 0; n < 6; n++)
            if (a[31:16] >= RLO[n] && a[31:16] <= RHI[n]) idx = n;
        return (idx < 0) ? 7'b1_000000 : {1'b0, 6'(1 << idx)};
    endfunction

    function automatic int ref_winner(input bit r1, input bit r2, input bit last_m2);
        if (r1 && r2) return last_m2 ? 1 : 2;
        return r1 ? 1 : 2;
    endfunction

    // Expected number of length errors when nb beats are sent, WLAST on the last one.
    function automatic int ref_errs(input int len, input int nb);
        int e, rem;
        e = 0;
        for (int i = 0; i < nb; i++) begin
            rem = (len > i) ? len - i : 0;
            if ((rem == 0) != (i == nb - 1)) e++;
        end
        return e;
    endfunction

    logic [1:0] o_grant, o_ph_addr, o_ph_resp, o_ph_end, o_grant_end;
    logic [5:0] o_sel;
    logic       o_dec, o_dec_end;
    bit         o_stable, trk;
    int         o_err;

    task automatic tk();
        @(posedge clk); #1;
        if (trk && (grant !== o_grant || slave_sel !== o_sel || decerr !== o_dec)) o_stable = 0;
    endtask

    task automatic reset_dut();
        rst = 1; awvalid_m1 = 0; awvalid_m2 = 0; awaddr_m1 = 0; awaddr_m2 = 0;
        awlen_m1 = 0; awlen_m2 = 0; aw_hs = 0; w_hs = 0; wlast = 0; b_hs = 0; trk = 0;
        tk(); tk();
        rst = 0;
        tk();
        model_last_m2 = 1;
    endtask

    // Drives one full transaction from IDLE and records what the DUT showed.
    task automatic drive_txn(input bit r1, input bit r2, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [3:0] l1, input logic [3:0] l2, input int nb,
                             input int stall, input bit keep);
        int e0;
        e0 = err_pulses;
        awvalid_m1 = r1; awaddr_m1 = a1; awlen_m1 = l1;
        awvalid_m2 = r2; awaddr_m2 = a2; awlen_m2 = l2;
        tk();
        o_grant = grant; o_sel = slave_sel; o_dec = decerr; o_ph_addr = phase;
        o_stable = 1; trk = 1;
        if (!keep) begin awvalid_m1 = 0; awvalid_m2 = 0; end
        repeat (stall) tk();
        aw_hs = 1; tk(); aw_hs = 0;
        for (int i = 0; i < nb; i++) begin
            repeat (stall) tk();
            w_hs = 1; wlast = (i == nb - 1); tk(); w_hs = 0; wlast = 0;
        end
        o_ph_resp = phase;
        repeat (stall) tk();
        b_hs = 1; trk = 0; tk(); b_hs = 0;
        o_ph_end = phase; o_grant_end = grant; o_dec_end = decerr;
        o_err = err_pulses - e0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b expected 00", grant); end
        tests++; if ({slave_sel, decerr} !== 7'b0) begin fails++; $display("FAIL reset_sel: got %b/%b expected 0", slave_sel, decerr); end
        tests++; if ({phase, wlast_err, timeout} !== 4'b0) begin fails++; $display("FAIL reset_misc: got %b expected 0000", {phase, wlast_err, timeout}); end
    endtask

    task automatic test_single();
        drive_txn(1, 0, 32'h0001_0000, 32'h0, 4'd0, 4'd0, 1, 0, 0);
        model_last_m2 = 0;
        tests++; if (o_grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b expected 01", o_grant); end
        tests++; if (o_sel !== 6'b000010) begin fails++; $display("FAIL single_sel: got %b expected 000010", o_sel); end
        tests++; if (o_ph_addr !== 2'd1) begin fails++; $display("FAIL single_phase_addr: got %0d expected 1", o_ph_addr); end
        tests++; if ({o_ph_end, o_grant_end} !== 4'b0) begin fails++; $display("FAIL single_end: got phase %0d grant %b expected 0/00", o_ph_end, o_grant_end); end
        tests++; if (o_err !== 0) begin fails++; $display("FAIL single_wlast_err: got %0d expected 0", o_err); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [1:0] lit [4];
        lit = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            w = ref_winner(1, 1, model_last_m2);
            drive_txn(1, 1, 32'h0002_0000, 32'h0002_0000, 4'd1, 4'd1, 2, k, 1);
            model_last_m2 = (w == 2);
            tests++; if (o_grant !== lit[k] || o_grant !== ((w == 1) ? 2'b01 : 2'b10))
                begin fails++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, o_grant, lit[k]); end
            tests++; if (o_sel !== 6'b000100) begin fails++; $display("FAIL b2b_sel[%0d]: got %b expected 000100", k, o_sel); end
            tests++; if ({o_ph_end, o_grant_end} !== 4'b0) begin fails++; $display("FAIL b2b_idle_gap[%0d]: got phase %0d grant %b expected 0/00", k, o_ph_end, o_grant_end); end
        end
        awvalid_m1 = 0; awvalid_m2 = 0;
        tk();
    endtask

    task automatic test_wlast_err();
        drive_txn(0, 1, 32'h0, 32'h2000_0040, 4'd0, 4'd3, 2, 1, 0);
        model_last_m2 = 1;
        tests++; if (o_err !== ref_errs(3, 2) || o_err !== 1) begin fails++; $display("FAIL wlast_err_count: got %0d expected 1", o_err); end
        tests++; if (o_ph_resp !== 2'd3) begin fails++; $display("FAIL wlast_err_phase: got %0d expected 3", o_ph_resp); end
        tests++; if (o_sel !== 6'b100000 || !o_stable) begin fails++; $display("FAIL wlast_err_sel: got %b stable %0d expected 100000 stable 1", o_sel, o_stable); end
    endtask

    task automatic test_decerr();
        drive_txn(1, 0, 32'h3000_0000, 32'h0, 4'd1, 4'd0, 2, 2, 0);
        model_last_m2 = 0;
        tests++; if ({o_dec, o_sel} !== 7'b1_000000 || !o_stable) begin fails++; $display("FAIL decerr_held: got %b/%b stable %0d expected 1/000000", o_dec, o_sel, o_stable); end
        tests++; if (o_dec_end !== 1'b0) begin fails++; $display("FAIL decerr_clear: got %b expected 0", o_dec_end); end
    endtask

    task automatic test_random();
        logic [15:0] pool [10];
        logic [31:0] a1, a2;
        logic [3:0]  l1, l2;
        bit r1, r2;
        int w, nb, to0;
        logic [6:0] ed;
        pool = '{16'h0000, 16'h0001, 16'h0002, 16'h1002, 16'h1001, 16'h2000, 16'h201F, 16'h2020, 16'h1FFF, 16'h0003};
        to0 = to_pulses;
        for (int t = 0; t < 40; t++) begin
            r1 = $urandom_range(0, 1); r2 = $urandom_range(0, 1);
            if (!r1 && !r2) r2 = 1;
            a1 = {pool[$urandom_range(0, 9)], 16'($urandom)};
            a2 = (t % 7 == 0) ? $urandom : {pool[$urandom_range(0, 9)], 16'($urandom)};
            l1 = 4'($urandom_range(0, 7)); l2 = 4'($urandom_range(0, 7));
            nb = $urandom_range(1, 6);
            w  = ref_winner(r1, r2, model_last_m2);
            ed = ref_decode((w == 1) ? a1 : a2);
            drive_txn(r1, r2, a1, a2, l1, l2, nb, $urandom_range(0, 3), 0);
            model_last_m2 = (w == 2);
            tests++; if (o_grant !== ((w == 1) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL rnd_grant[%0d]: got %b expected M%0d", t, o_grant, w); end
            tests++; if ({o_dec, o_sel} !== ed) begin fails++; $display("FAIL rnd_decode[%0d]: got %b expected %b", t, {o_dec, o_sel}, ed); end
            tests++; if (o_err !== ref_errs(int'((w == 1) ? l1 : l2), nb)) begin fails++; $display("FAIL rnd_wlast_err[%0d]: got %0d expected %0d", t, o_err, ref_errs(int'((w == 1) ? l1 : l2), nb)); end
            tests++; if (!o_stable || o_ph_addr !== 2'd1 || o_ph_resp !== 2'd3) begin fails++; $display("FAIL rnd_flow[%0d]: got stable %0d phases %0d/%0d expected 1 1/3", t, o_stable, o_ph_addr, o_ph_resp); end
            tests++; if ({o_ph_end, o_grant_end, o_dec_end} !== 5'b0) begin fails++; $display("FAIL rnd_end[%0d]: got %b expected 0", t, {o_ph_end, o_grant_end, o_dec_end}); end
        end
        tests++; if (to_pulses !== to0) begin fails++; $display("FAIL rnd_no_timeout: got %0d expected 0", to_pulses - to0); end
    endtask

    task automatic test_timeout();
        int cyc, to0;
        to0 = to_pulses;
        awvalid_m1 = 1; awaddr_m1 = 32'h0000_1234; awlen_m1 = 0;
        tk();
        awvalid_m1 = 0;
        tests++; if (phase !== 2'd1 || grant !== 2'b01) begin fails++; $display("FAIL to_addr: got phase %0d grant %b expected 1/01", phase, grant); end
        cyc = 0;
        for (int c = 1; c <= 24 && cyc == 0; c++) begin
            tk();
            if (timeout === 1'b1) cyc = c;
        end
        tests++; if (cyc !== 16) begin fails++; $display("FAIL to_latency: got %0d expected 16", cyc); end
        tests++; if (phase !== 2'd0 || grant !== 2'b00 || slave_sel !== 6'b0) begin fails++; $display("FAIL to_abort: got phase %0d grant %b sel %b expected 0", phase, grant, slave_sel); end
        tk();
        model_last_m2 = 0;
        tests++; if (timeout !== 1'b0 || to_pulses - to0 !== 1) begin fails++; $display("FAIL to_pulse: got %b count %0d expected 0 count 1", timeout, to_pulses - to0); end
        drive_txn(1, 1, 32'h0000_0000, 32'h1001_0000, 4'd0, 4'd0, 1, 0, 0);
        tests++; if (o_grant !== 2'b10 || o_grant !== ((ref_winner(1, 1, model_last_m2) == 1) ? 2'b01 : 2'b10))
            begin fails++; $display("FAIL to_rr: got %b expected 10", o_grant); end
        model_last_m2 = 1;
    endtask

    task automatic test_reset_mid();
        awvalid_m1 = 1; awaddr_m1 = 32'h0000_0000; awlen_m1 = 4'd4;
        tk();
        awvalid_m1 = 0;
        aw_hs = 1; tk(); aw_hs = 0;
        w_hs = 1; tk(); tk(); w_hs = 0;
        tests++; if (phase !== 2'd2) begin fails++; $display("FAIL rstmid_pre: got phase %0d expected 2", phase); end
        #2 rst = 1;
        #1;
        tests++; if ({grant, slave_sel, decerr, phase, wlast_err, timeout} !== 13'b0)
            begin fails++; $display("FAIL rstmid_async: got %b expected 0", {grant, slave_sel, decerr, phase, wlast_err, timeout}); end
        #1 rst = 0;
        model_last_m2 = 1;
        tk();
        drive_txn(1, 1, 32'h1002_0000, 32'h0, 4'd0, 4'd0, 1, 0, 0);
        tests++; if (o_grant !== 2'b01 || o_sel !== 6'b001000) begin fails++; $display("FAIL rstmid_after: got %b/%b expected 01/001000", o_grant, o_sel); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wlast_err();
        test_decerr();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
